char_glyph_loader: RTL
======================

Name: char_glyph_loader

Overview:
- Writer side of the per-character glyph memories. Each character cell stores a 12-bit glyph: 4 rows (y=0..3), 3 writable columns (x=1..3). Column x=0 is the fixed blank pad.
- Accepts a byte stream from the Arduino host interface through a valid/ready handshake and decodes load or clear commands.
- Serializes each command into 12 single-bit writes (char select, x, y, data) aimed at the addressed glyph memory.

Parameters:
- CHAR_IDX_W, 6, width of character index; addresses up to 2**CHAR_IDX_W glyph memories.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte; byte is consumed when in_valid && in_ready at a clock edge.
- err_clr  in  1  clears sticky err.
- wr_en  out  1  write strobe to the glyph memory array.
- wr_char  out  CHAR_IDX_W  target character index.
- wr_x  out  2  column, always 1..3 when wr_en=1.
- wr_y  out  3  row, always 0..3 when wr_en=1.
- wr_data  out  1  pixel bit.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky: reserved opcode received.

Behaviour:
- States: IDLE, DATA0, DATA1, WRITE.
- Header byte: opcode = in_data[7:6], char index = in_data[CHAR_IDX_W-1:0].
- Opcodes:
  - 00: NOP, stay in IDLE.
  - 01: LOAD, go to DATA0.
  - 10: CLEAR, load glyph buffer with 12'h000 and go straight to WRITE.
  - 11: reserved, set err, stay in IDLE.
- DATA0: accepted byte bits[5:0] go to glyph[5:0]; go to DATA1. DATA1: accepted byte bits[5:0] go to glyph[11:6]; go to WRITE. Bits[7:6] of data bytes are ignored.
- in_ready = rst_n && state is IDLE, DATA0 or DATA1 (combinational). It is 0 throughout WRITE.
- WRITE:
  - 4-bit counter k runs 0..11, one write per cycle.
  - wr_en=1 for exactly 12 consecutive cycles.
  - wr_y = k/3, wr_x = (k mod 3)+1, wr_data = glyph[k], wr_char = latched index.
  - After k=11, return to IDLE. in_ready is 1 in the cycle after the last write.
- Latency: first wr_en cycle is the cycle immediately after the edge that accepted the final command byte (DATA1 byte for LOAD, header for CLEAR). Header accept to last write is 15 cycles for LOAD (header + 2 data bytes) when bytes arrive back to back.
- Outputs are registered. When wr_en=0, wr_x, wr_y and wr_data are 0; wr_char holds its last value.
- Reset values: state IDLE, wr_en 0, wr_x 0, wr_y 0, wr_data 0, wr_char 0, busy 0, err 0, k 0, glyph buffer 0.
- Reset mid-command (DATA0/DATA1/WRITE): abort. No further writes; wr_en is 0 from the edge where rst_n is sampled low. A partially written glyph is left as is.
- in_valid low while in DATA0/DATA1: wait indefinitely, no timeout.
- err_clr and a reserved opcode in the same cycle: set wins, err=1.
- In IDLE, the index byte of a CLEAR/LOAD header is latched only on acceptance. The index is never altered during WRITE.

Optional Feature:
- Macro LOADER_COUNT_EN.
- Defined: adds output glyph_count[7:0]. It increments (wrapping 255 to 0) on the cycle the k=11 write completes, for both LOAD and CLEAR. Reset value 0. Reset mid-command does not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then LOAD: bytes 0x45, 0x15, 0x2A (glyph 12'hA95), char 5 -> 12 writes, wr_char=5.
  - (x,y,d) sequence: (1,0,1),(2,0,0),(3,0,1),(1,1,0),(2,1,1),(3,1,0),(1,2,0),(2,2,1),(3,2,0),(1,3,1),(2,3,0),(3,3,1).
  - in_ready=0 during the writes, busy=1.
- CLEAR 0x83 -> 12 writes to char 3, all wr_data=0, starting the cycle after the header is accepted. in_ready returns to 1 after 12 cycles.
- Header 0xC0 -> err=1, no wr_en, stays IDLE. err_clr pulse -> err=0. err_clr together with 0xC0 -> err stays 1.
- LOAD 0x41, 0x3F, then in_valid low for 5 cycles, then 0x3F -> no writes during the stall, then 12 writes of 1 to char 1.
- Reset asserted at k=6 of a LOAD -> wr_en=0 from that edge, busy=0, and a fresh CLEAR 0x82 afterwards performs exactly 12 writes.
- LOADER_COUNT_EN: 257 back-to-back CLEAR commands -> glyph_count=1. NOP 0x00 does not increment.

Source files
------------

// File: rtl/char_glyph_loader.sv
// char_glyph_loader: decodes host LOAD/CLEAR byte commands into 12 serial glyph pixel writes; define LOADER_COUNT_EN to add glyph_count
module char_glyph_loader #(
  parameter int CHAR_IDX_W = 6
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  err_clr,
  output logic                  wr_en,
  output logic [CHAR_IDX_W-1:0] wr_char,
  output logic [1:0]            wr_x,
  output logic [2:0]            wr_y,
  output logic                  wr_data,
  output logic                  busy,
`ifdef LOADER_COUNT_EN
  output logic [7:0]            glyph_count,
`endif
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, DATA0, DATA1, WRITE} state_t;
  state_t state;
  logic [11:0] glyph;
  logic [CHAR_IDX_W-1:0] idx;
  logic [3:0] k, kn;
  logic acc;
  assign in_ready = rst_n && state != WRITE;
  assign busy = state != IDLE;
  assign acc = in_valid && in_ready;
  assign kn = k + 4'd1;
  // command decode, data capture and the 12-cycle write sweep (k indexes the write being presented)
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= IDLE;
      glyph <= '0;
      idx <= '0;
      k <= '0;
      wr_en <= 1'b0;
      wr_char <= '0;
      wr_x <= '0;
      wr_y <= '0;
      wr_data <= 1'b0;
      err <= 1'b0;
`ifdef LOADER_COUNT_EN
      glyph_count <= '0;
`endif
    end else begin
      if (acc && state == IDLE && in_data[7:6] == 2'b11) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (in_data[7:6] == 2'b01) begin
            idx <= in_data[CHAR_IDX_W-1:0];
            state <= DATA0;
          end else if (in_data[7:6] == 2'b10) begin
            idx <= in_data[CHAR_IDX_W-1:0];
            wr_char <= in_data[CHAR_IDX_W-1:0];
            glyph <= '0;
            k <= '0;
            wr_en <= 1'b1;
            wr_x <= 2'd1;
            wr_y <= 3'd0;
            wr_data <= 1'b0;
            state <= WRITE;
          end
        end
        DATA0: if (acc) begin
          glyph[5:0] <= in_data[5:0];
          state <= DATA1;
        end
        DATA1: if (acc) begin
          glyph[11:6] <= in_data[5:0];
          wr_char <= idx;
          k <= '0;
          wr_en <= 1'b1;
          wr_x <= 2'd1;
          wr_y <= 3'd0;
          wr_data <= glyph[0];
          state <= WRITE;
        end
        WRITE: if (k == 4'd11) begin
          k <= '0;
          wr_en <= 1'b0;
          wr_x <= '0;
          wr_y <= '0;
          wr_data <= 1'b0;
          state <= IDLE;
`ifdef LOADER_COUNT_EN
          glyph_count <= glyph_count + 8'd1;
`endif
        end else begin
          k <= kn;
          wr_x <= wr_x == 2'd3 ? 2'd1 : wr_x + 2'd1;
          wr_y <= wr_x == 2'd3 ? wr_y + 3'd1 : wr_y;
          wr_data <= glyph[kn];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
